// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers
// for the binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESHOLD = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int unsigned max_value(
    input int unsigned digits
  );
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Nibble correction for the double-dabble shift:
// add 3 to any digit that would exceed 9 after doubling.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_nib,
  output logic [BCD_DIGIT_W-1:0] o_nib
);

  logic w_ge;

  assign w_ge  = i_nib >= BCD_DIGIT_W'(ADD3_THRESHOLD);
  assign o_nib = w_ge ? i_nib + BCD_DIGIT_W'(3) : i_nib;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 converter, one input bit
// per clock, with a held, saturating result register.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [BIN_WIDTH-1:0]       binary,
  output logic                       busy,
  output logic                       done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                       overflow
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VALUE =
    32'(max_value(DIGITS));

  state_e               r_state;
  state_e               w_next;
  logic [BIN_WIDTH-1:0] r_sr;
  logic [SCR_W-1:0]     r_scr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [SCR_W-1:0]     r_bcd;
  logic                 r_ovf_out;
  logic                 r_done;

  logic [SCR_W-1:0]     w_adj;
  logic [SCR_W-1:0]     w_scr_sh;
  logic [BIN_WIDTH-1:0] w_sr_sh;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_ovf_in;
  logic                 w_unused_msb;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_nib (r_scr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_nib (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Top scratch bit falls off; overflowed inputs are
  // replaced by the saturated value anyway.
  assign w_unused_msb = w_adj[SCR_W-1];
  assign w_scr_sh = {w_adj[SCR_W-2:0], r_sr[BIN_WIDTH-1]};
  assign w_sr_sh  = {r_sr[BIN_WIDTH-2:0], 1'b0};

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == SHIFT) &&
                    (r_cnt == CNT_W'(1));
  assign w_ovf_in = 32'(binary) > MAX_VALUE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start)  w_next = SHIFT;
      SHIFT: if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (r_state)
      IDLE:  busy = 1'b0;
      SHIFT: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr  <= '0;
      r_scr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_sr  <= binary;
      r_scr <= '0;
      r_cnt <= CNT_W'(BIN_WIDTH);
      r_ovf <= w_ovf_in;
    end else if (r_state == SHIFT) begin
      r_sr  <= w_sr_sh;
      r_scr <= w_scr_sh;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_bcd     <= r_ovf ? {DIGITS{4'h9}} : w_scr_sh;
        r_ovf_out <= r_ovf;
      end
    end
  end

  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf_out;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed plus randomized checks of bin_to_bcd
// against an arithmetic decimal-digit model.
module tb_bin_to_bcd;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [13:0] binary;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  bin_to_bcd #(
    .BIN_WIDTH (14),
    .DIGITS    (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .binary   (binary),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(
    input int unsigned v
  );
    logic [15:0] r;
    int unsigned p;
    if (v > 9999) return 16'h9999;
    r = '0;
    p = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  task automatic run(input int unsigned v);
    int nb;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    binary = 14'(v);
    @(negedge clk);
    start  = 1'b0;
    binary = 14'($urandom);
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk("busy_cycles", nb, 14);
    chk("busy_at_done", 32'(busy), 0);
    chk("bcd", 32'(bcd), 32'(ref_bcd(v)));
    chk("overflow", 32'(overflow), 32'(v > 9999));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [15:0] got;
    int t [3];
    int vals [3];
    vals = '{8, 9, 10};

    reset_n = 1'b0;
    start   = 1'b0;
    binary  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clk);

    run(0);
    run(1234);
    run(9999);
    run(10000);
    run(16383);
    run(5);

    run(1234);
    repeat (5) @(negedge clk);
    chk("hold_bcd", 32'(bcd), 32'h1234);
    chk("hold_ovf", 32'(overflow), 0);

    // second request while busy must be dropped
    @(negedge clk);
    start  = 1'b1;
    binary = 14'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start  = 1'b1;
    binary = 14'd77;
    repeat (5) @(negedge clk);
    start = 1'b0;
    nd  = 0;
    got = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) got = bcd;
      end
    end
    chk("ign_done_count", nd, 1);
    chk("ign_bcd", 32'(got), 32'h0042);

    // start held high: back-to-back conversions
    @(negedge clk);
    start  = 1'b1;
    binary = 14'(vals[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      binary = (k < 2) ? 14'(vals[k+1]) : 14'd0;
      for (int i = 0; i < 30 && !done; i++)
        @(negedge clk);
      chk("b2b_done", 32'(done), 1);
      t[k] = cycle;
      chk("b2b_bcd", 32'(bcd),
          32'(ref_bcd(32'(vals[k]))));
      if (k == 2) start = 1'b0;
    end
    chk("b2b_gap1", t[1] - t[0], 15);
    chk("b2b_gap2", t[2] - t[1], 15);
    @(negedge clk);
    chk("b2b_stop", 32'(done), 0);

    // reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    binary = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd), 0);
    chk("abort_ovf", 32'(overflow), 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_idle_no_done", nd, 0);
    chk("abort_bcd_idle", 32'(bcd), 0);
    run(5678);

    for (int i = 0; i < 200; i++)
      run($urandom_range(0, 9999));
    for (int i = 0; i < 100; i++)
      run($urandom_range(0, 16383));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
